// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - requester-side request/response bundle for the shared adder arbiter
// Requester i owns slice [i*DATA_WIDTH +: DATA_WIDTH] of req_a/req_b.
interface adder_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_sum;
    logic                          rsp_carry;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_sum, rsp_carry
    );
endinterface

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequencer sharing one fixed-latency adder among NUM_REQ requesters
// One operation in flight at a time: IDLE (grant) -> WAIT (adder latency) -> RESP (one-hot pulse).
module adder_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  enable,
    adder_arbiter_if.slave        bus,
    output logic                  busy,
    output logic                  add_enable,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    input  logic [DATA_WIDTH-1:0] add_sum,
    input  logic                  add_carry
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [IDXW-1:0]       r_owner;
    logic [IDXW-1:0]       r_last;
    logic [CNTW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_sum;
    logic                  r_rsp_carry;
    logic [DATA_WIDTH-1:0] r_add_a;
    logic [DATA_WIDTH-1:0] r_add_b;
    logic                  r_add_enable;

    logic                  w_found;
    logic [IDXW-1:0]       w_grant_idx;
    logic [NUM_REQ-1:0]    w_grant;

    function automatic logic [IDXW-1:0] wrap_idx(input int v);
        return IDXW'(v % NUM_REQ);
    endfunction

    // Search starts just after the last winner, so a held request waits at most NUM_REQ-1 grants.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && bus.req_valid[wrap_idx(int'(r_last) + k)]) begin
                w_found     = 1'b1;
                w_grant_idx = wrap_idx(int'(r_last) + k);
            end
        end
    end

    assign w_grant = (enable && (r_state == S_IDLE) && w_found)
                   ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx)
                   : '0;

    always_ff @(posedge clk) begin
        if (!enable) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last       <= IDXW'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_sum    <= '0;
            r_rsp_carry  <= 1'b0;
            r_add_a      <= '0;
            r_add_b      <= '0;
            r_add_enable <= 1'b0;
        end else begin
            r_add_enable <= 1'b1;
            r_rsp_valid  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_add_a <= bus.req_a[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_add_b <= bus.req_b[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                        r_owner <= w_grant_idx;
                        r_last  <= w_grant_idx;
                        r_cnt   <= CNTW'(ADD_LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_sum   <= add_sum;
                        r_rsp_carry <= add_carry;
                        r_rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_carry = r_rsp_carry;
    assign busy          = (r_state != S_IDLE);
    assign add_enable    = r_add_enable;
    assign add_a         = r_add_a;
    assign add_b         = r_add_b;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter at latency 1 and latency 3
module tb_adder_arbiter;
    logic clk;
    logic enable;

    adder_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus0 ();
    adder_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus1 ();

    logic        busy0, add_en0, add_c0;
    logic [31:0] add_a0, add_b0, add_s0;
    logic        busy1, add_en1, add_c1;
    logic [31:0] add_a1, add_b1, add_s1;
    logic [32:0] p1, p2;

    int errors = 0;
    int checks = 0;

    adder_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .ADD_LATENCY(1)) dut0 (
        .clk(clk), .enable(enable), .bus(bus0), .busy(busy0), .add_enable(add_en0),
        .add_a(add_a0), .add_b(add_b0), .add_sum(add_s0), .add_carry(add_c0)
    );

    adder_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .ADD_LATENCY(3)) dut1 (
        .clk(clk), .enable(enable), .bus(bus1), .busy(busy1), .add_enable(add_en1),
        .add_a(add_a1), .add_b(add_b1), .add_sum(add_s1), .add_carry(add_c1)
    );

    // Latency-1 model: result ready within the cycle after operands change.
    assign {add_c0, add_s0} = {1'b0, add_a0} + {1'b0, add_b0};

    // Latency-3 model: combinational sum followed by two register stages.
    always @(posedge clk) begin
        p1 <= {1'b0, add_a1} + {1'b0, add_b1};
        p2 <= p1;
    end
    assign {add_c1, add_s1} = p2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [31:0] opa [4];
    logic [31:0] opb [4];
    int order [5];

    initial begin
        enable = 1'b0;
        bus0.req_valid = '0; bus0.req_a = '0; bus0.req_b = '0;
        bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 32'h11111111 * (i + 1);
            opb[i] = i + 1;
        end
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        // Reset state
        step(); step();
        smp();
        chk("rst_ready", bus0.req_ready, 4'b0000);
        chk("rst_rsp_valid", bus0.rsp_valid, 4'b0000);
        chk("rst_rsp_sum", bus0.rsp_sum, 0);
        chk("rst_rsp_carry", bus0.rsp_carry, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_add_enable", add_en0, 0);
        chk("rst_add_a", add_a0, 0);

        // Single request from requester 1
        step();
        enable = 1'b1;
        bus0.req_valid = 4'b0010;
        bus0.req_a[1*32 +: 32] = 32'h5;
        bus0.req_b[1*32 +: 32] = 32'h7;
        smp();
        chk("single_ready", bus0.req_ready, 4'b0010);
        step();
        bus0.req_valid = '0;
        smp();
        chk("single_wait_busy", busy0, 1);
        chk("single_wait_ready", bus0.req_ready, 0);
        chk("single_wait_rsp", bus0.rsp_valid, 0);
        chk("single_add_a", add_a0, 32'h5);
        chk("single_add_en", add_en0, 1);
        step(); smp();
        chk("single_rsp_valid", bus0.rsp_valid, 4'b0010);
        chk("single_rsp_sum", bus0.rsp_sum, 32'hC);
        chk("single_rsp_carry", bus0.rsp_carry, 0);
        step(); smp();
        chk("single_after_rsp", bus0.rsp_valid, 0);
        chk("single_after_busy", busy0, 0);
        chk("single_sum_hold", bus0.rsp_sum, 32'hC);

        // Overflow through requester 0
        bus0.req_valid = 4'b0001;
        bus0.req_a[31:0] = 32'hFFFFFFFF;
        bus0.req_b[31:0] = 32'h00000001;
        step(); bus0.req_valid = '0;
        step(); smp();
        chk("ovf1_rsp_valid", bus0.rsp_valid, 4'b0001);
        chk("ovf1_sum", bus0.rsp_sum, 0);
        chk("ovf1_carry", bus0.rsp_carry, 1);
        step();
        bus0.req_valid = 4'b0001;
        bus0.req_a[31:0] = 32'h80000000;
        bus0.req_b[31:0] = 32'h80000000;
        smp();
        chk("ovf2_ready", bus0.req_ready, 4'b0001);
        step(); bus0.req_valid = '0;
        step(); smp();
        chk("ovf2_sum", bus0.rsp_sum, 0);
        chk("ovf2_carry", bus0.rsp_carry, 1);
        step();

        // All four held from reset: grants 0,1,2,3,0 spaced 3 cycles apart
        enable = 1'b0;
        bus0.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus0.req_a[i*32 +: 32] = opa[i];
            bus0.req_b[i*32 +: 32] = opb[i];
        end
        smp();
        chk("rr_rst_ready", bus0.req_ready, 0);
        step();
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("rr_grant", bus0.req_ready, 4'b0001 << order[k]);
            step(); smp();
            chk("rr_wait_ready", bus0.req_ready, 0);
            step(); smp();
            chk("rr_rsp_valid", bus0.rsp_valid, 4'b0001 << order[k]);
            chk("rr_rsp_sum", bus0.rsp_sum, opa[order[k]] + opb[order[k]]);
            step();
        end

        // Fairness: req0 held, req2 raised during req0's WAIT
        bus0.req_valid = 4'b0001;
        smp();
        chk("fair_grant0", bus0.req_ready, 4'b0001);
        step();
        bus0.req_valid = 4'b0101;
        step(); step(); smp();
        chk("fair_grant2", bus0.req_ready, 4'b0100);
        step();
        bus0.req_valid = 4'b0001;
        step(); smp();
        chk("fair_rsp2", bus0.rsp_valid, 4'b0100);
        chk("fair_sum2", bus0.rsp_sum, opa[2] + opb[2]);
        step(); smp();
        chk("fair_grant0_again", bus0.req_ready, 4'b0001);
        step();
        bus0.req_valid = '0;
        step(); smp();
        chk("fair_rsp0", bus0.rsp_valid, 4'b0001);
        step();

        // Reset during WAIT drops the operation and restarts the pointer
        bus0.req_valid = 4'b0010;
        smp();
        chk("midrst_grant", bus0.req_ready, 4'b0010);
        step();
        bus0.req_valid = '0;
        enable = 1'b0;
        smp();
        chk("midrst_busy_wait", busy0, 1);
        step();
        enable = 1'b1;
        smp();
        chk("midrst_busy", busy0, 0);
        chk("midrst_rsp_valid", bus0.rsp_valid, 0);
        chk("midrst_rsp_sum", bus0.rsp_sum, 0);
        chk("midrst_add_a", add_a0, 0);
        chk("midrst_add_en", add_en0, 0);
        for (int k = 0; k < 3; k++) begin
            step(); smp();
            chk("midrst_no_rsp", bus0.rsp_valid, 0);
        end
        bus0.req_valid = 4'b1111;
        #1;
        chk("midrst_ptr", bus0.req_ready, 4'b0001);
        bus0.req_valid = '0;

        // Latency 3 instance: a=100, b=23
        step();
        bus1.req_valid = 4'b0001;
        bus1.req_a[31:0] = 32'd100;
        bus1.req_b[31:0] = 32'd23;
        smp();
        chk("lat3_grant", bus1.req_ready, 4'b0001);
        chk("lat3_idle_busy", busy1, 0);
        step();
        bus1.req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk("lat3_wait_busy", busy1, 1);
            chk("lat3_wait_rsp", bus1.rsp_valid, 0);
            step();
        end
        smp();
        chk("lat3_rsp_valid", bus1.rsp_valid, 4'b0001);
        chk("lat3_rsp_sum", bus1.rsp_sum, 32'd123);
        chk("lat3_rsp_busy", busy1, 1);
        step(); smp();
        chk("lat3_done_busy", busy1, 0);
        chk("lat3_done_rsp", bus1.rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
